// File: rtl/div_16x8_seq.sv
// rtl/div_16x8_seq.sv - 16/8 unsigned sequential restoring divider, one quotient bit per cycle
module div_16x8_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_zero
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t     state, state_nxt;
    logic [3:0] iter_cnt;
    logic [7:0] dsr;
    logic [8:0] pr_shift;
    logic [7:0] diff;
    logic       ge;

    // quotient doubles as the dividend shift register: dividend bits leave at
    // the top while quotient bits enter at the bottom
    assign pr_shift = {remainder, quotient[15]};
    assign ge       = pr_shift >= {1'b0, dsr};
    assign diff     = pr_shift[7:0] - dsr;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = (divisor == 8'd0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (iter_cnt == 4'd15) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient  <= 16'h0000;
            remainder <= 8'h00;
            div_zero  <= 1'b0;
            dsr       <= 8'h00;
            iter_cnt  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dsr      <= divisor;
                        iter_cnt <= 4'd0;
                        if (divisor == 8'd0) begin
                            quotient  <= 16'hFFFF;
                            remainder <= dividend[7:0];
                            div_zero  <= 1'b1;
                        end else begin
                            quotient  <= dividend;
                            remainder <= 8'h00;
                            div_zero  <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    quotient  <= {quotient[14:0], ge};
                    remainder <= ge ? diff : pr_shift[7:0];
                    iter_cnt  <= iter_cnt + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_16x8_seq.sv
// tb/tb_div_16x8_seq.sv - self-checking bench for div_16x8_seq
module tb_div_16x8_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    div_16x8_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division; zero divisor gives all-ones quotient.
    task automatic model(input logic [15:0] a, input logic [7:0] b,
                         output logic [15:0] q, output logic [7:0] r,
                         output logic dz, output int lat);
        if (b == 8'd0) begin
            q = 16'hFFFF; r = a[7:0]; dz = 1'b1; lat = 1;
        end else begin
            q = a / b; r = 8'(a % b); dz = 1'b0; lat = 17;
        end
    endtask

    // Called at a negedge with the divider idle. Latency counts the accepting
    // edge as edge 1.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] eq, input logic [7:0] er,
                          input logic edz, input int elat, input string tag);
        int lat;
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; dividend = a; divisor = b;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0; dividend = ~a; divisor = ~b;
        while (!out_valid && lat < 40) begin
            chk({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
            @(posedge clk); lat++;
            @(negedge clk);
        end
        chk({tag, " latency"}, 32'(lat), 32'(elat));
        chk({tag, " quotient"}, 32'(quotient), 32'(eq));
        chk({tag, " remainder"}, 32'(remainder), 32'(er));
        chk({tag, " div_zero"}, 32'(div_zero), 32'(edz));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] eq;
        logic [7:0]  er;
        logic        edz;
        int          elat;
        int          lat;
        logic [15:0] ra;
        logic [7:0]  rb;

        vecs[0] = '{16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 17};
        vecs[1] = '{16'd1000, 8'd7,  16'd142,  8'd6,  1'b0, 17};
        vecs[2] = '{16'd5,    8'd9,  16'd0,    8'd5,  1'b0, 17};
        vecs[3] = '{16'h1234, 8'd0,  16'hFFFF, 8'h34, 1'b1, 1};
        vecs[4] = '{16'd100,  8'd10, 16'd10,   8'd0,  1'b0, 17};
        vecs[5] = '{16'd0,    8'd1,  16'd0,    8'd0,  1'b0, 17};
        vecs[6] = '{16'hFFFF, 8'd1,  16'hFFFF, 8'd0,  1'b0, 17};
        vecs[7] = '{16'h8000, 8'd3,  16'd10922, 8'd2, 1'b0, 17};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        dividend = 16'h0; divisor = 8'h0;
        #3;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset quotient", 32'(quotient), 32'd0);
        chk("reset remainder", 32'(remainder), 32'd0);
        chk("reset div_zero", 32'(div_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat,
                   $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            model(ra, rb, eq, er, edz, elat);
            run_op(ra, rb, eq, er, edz, elat, $sformatf("rnd%0d %0d/%0d", i, ra, rb));
        end

        // Result held under backpressure while new operands sit on the inputs.
        in_valid = 1'b1; dividend = 16'd1000; divisor = 8'd7;
        @(posedge clk);
        @(negedge clk);
        dividend = 16'h1234; divisor = 8'd0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
        chk("hold latency", 32'(lat), 32'd17);
        for (int c = 0; c < 5; c++) begin
            chk("hold quotient", 32'(quotient), 32'd142);
            chk("hold remainder", 32'(remainder), 32'd6);
            chk("hold div_zero", 32'(div_zero), 32'd0);
            chk("hold in_ready", 32'(in_ready), 32'd0);
            chk("hold out_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("handoff in_ready", 32'(in_ready), 32'd1);
        chk("handoff out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pending dz out_valid", 32'(out_valid), 32'd1);
        chk("pending dz quotient", 32'(quotient), 32'hFFFF);
        chk("pending dz remainder", 32'(remainder), 32'h34);
        chk("pending dz div_zero", 32'(div_zero), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of CALC, after eight iterations.
        in_valid = 1'b1; dividend = 16'd1000; divisor = 8'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort in_ready", 32'(in_ready), 32'd1);
        chk("abort quotient", 32'(quotient), 32'd0);
        chk("abort remainder", 32'(remainder), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'd100, 8'd10, 16'd10, 8'd0, 1'b0, 17, "post reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
